// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Step count and the zero-divisor quotient both follow from the divisor width.
package div_pkg;

    localparam int DIV_WIDTH = 6;
    localparam int DIV_STEPS = 2 * DIV_WIDTH;
    localparam logic [DIV_STEPS-1:0] DIV_DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter width able to hold steps-1, never narrower than one bit.
    function automatic int div_cnt_bits(input int steps);
        return (steps > 2) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
// Zero latency, no flow control of its own.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   pr,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   pr_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvsr_ext;

    // The partial remainder is always below the divisor, so its top bit is zero;
    // keeping it in the compare costs nothing and keeps the step self-contained.
    assign shifted  = {pr, q_msb};
    assign dvsr_ext = {2'b00, divisor};

    assign q_bit   = (shifted >= dvsr_ext);
    assign pr_next = q_bit ? (WIDTH+1)'(shifted - dvsr_ext) : shifted[WIDTH:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned 2W/W restoring divider, one quotient bit per clock; result 2*WIDTH edges after accept.
// Result holds stable until out_ready; no new operation is accepted until the result is taken.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int STEPS = 2 * WIDTH;
    localparam int CW    = div_cnt_bits(STEPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    div_state_t         state;
    logic [WIDTH:0]     pr;
    logic [2*WIDTH-1:0] q;
    logic [WIDTH-1:0]   dvsr;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     step_pr;
    logic               step_q;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .pr      (pr),
        .q_msb   (q[2*WIDTH-1]),
        .divisor (dvsr),
        .pr_next (step_pr),
        .q_bit   (step_q)
    );

    // The quotient shift register doubles as the dividend store while busy.
    assign quotient  = q;
    assign remainder = pr[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            pr          <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        pr       <= '0;
                        dvsr     <= divisor;
                        cnt      <= LAST_CNT;
                        if (divisor == '0) begin
                            q           <= '1;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q           <= dividend;
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    pr <= step_pr;
                    q  <= {q[2*WIDTH-2:0], step_q};
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider against hand-computed results.
module tb_seq_restoring_divider;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation and returns just after the accept edge.
    task automatic send(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit keep_valid);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Waits for the result, checks it, holds it for 'hold' cycles, then takes it.
    task automatic expect_result(input string tag, input int a, input int b,
                                 input int eq, input int er, input bit edbz,
                                 input int elat, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(elat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (!edbz) begin
            check({tag, "_invariant"}, 32'(int'(quotient) * b + int'(remainder)), 32'(a));
            check({tag, "_rem_lt_div"}, 32'(int'(remainder) < b), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_quotient"}, 32'(quotient), 32'(eq));
            check({tag, "_hold_remainder"}, 32'(remainder), 32'(er));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        bit seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        send(12'd100, 6'd7, 1'b0);
        expect_result("d100_7", 100, 7, 14, 2, 1'b0, 12, 0);

        send(12'd3969, 6'd63, 1'b0);
        expect_result("d3969_63", 3969, 63, 63, 0, 1'b0, 12, 0);
        send(12'd4095, 6'd1, 1'b0);
        expect_result("d4095_1", 4095, 1, 4095, 0, 1'b0, 12, 0);

        send(12'd5, 6'd0, 1'b0);
        expect_result("dbz", 5, 0, 4095, 0, 1'b1, 0, 0);
        send(12'd0, 6'd5, 1'b0);
        expect_result("d0_5", 0, 5, 0, 0, 1'b0, 12, 0);

        send(12'd4000, 6'd9, 1'b0);
        expect_result("bp4000_9", 4000, 9, 444, 4, 1'b0, 12, 5);

        // Operands change and in_valid stays high while busy.
        send(12'd100, 6'd7, 1'b1);
        dividend = 12'd2000;
        divisor  = 6'd13;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        expect_result("latched", 100, 7, 14, 2, 1'b0, 12, 1);
        tick();
        check("second_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        expect_result("second", 2000, 13, 153, 11, 1'b0, 12, 0);

        // Reset at the fifth busy step aborts the operation.
        send(12'd1000, 6'd7, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        send(12'd50, 6'd6, 1'b0);
        expect_result("d50_6", 50, 6, 8, 2, 1'b0, 12, 0);

        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 4095));
            b = int'($urandom_range(1, 63));
            send(12'(a), 6'(b), 1'b0);
            expect_result("rnd", a, b, a / b, a % b, 1'b0, 12, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
